adc_spi_muestreo: RTL and testbench
===================================

# adc_spi_muestreo

Upstream acquisition stage for `Filtro_Pasa_Baja_200_Hz`. Paces conversions from a 12-bit serial ADC (ADC7476-style, 16-bit frame: 4 leading zeros, then 12 data bits MSB first) with a fixed sample timer. Converts each offset-binary code into the filter's signed N-bit fixed-point format. Presents the result on `Uk` with a one-cycle `Bandera_ADC` strobe that starts one filter iteration.

## Interface
- `N`, 25: width of `Uk`; matches the filter's `N`.
- `F`, 15: fractional bits of `Uk`; F >= 11 and F + 2 <= N required.
- `SCLK_DIV`, 4: Clk cycles per SCLK half-period; SCLK = Clk/(2*SCLK_DIV).
- `SAMPLE_DIV`, 20000: Clk cycles per sample period (5 kHz at 100 MHz); must exceed 32*SCLK_DIV + 2.

- `Clk`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Sdata`  in  1  ADC serial data; the ADC changes it after SCLK falling edges.
- `Sclk`  out  1  ADC serial clock; idles high.
- `CS_n`  out  1  ADC chip select, active low.
- `Uk`  out  N  latest sample, signed two's complement, F fractional bits.
- `Bandera_ADC`  out  1  one-cycle strobe: new `Uk` valid.
- `Error_Trama`  out  1  qualified by `Bandera_ADC`; high if any of the 4 leading frame bits was 1.

## Operation
- Sample timer: free-running counter `0..SAMPLE_DIV-1`. It wraps to 0 and raises a one-cycle tick when the count equals SAMPLE_DIV-1. It runs in every state.
- FSM has three states: REPOSO, CONV and LISTO.
- REPOSO:
  - Outputs: CS_n=1, Sclk=1.
  - A tick moves the FSM to CONV, clearing the bit counter (0..15) and the phase counter (0..2*SCLK_DIV-1).
- CONV:
  - CS_n=0.
  - Sclk=0 while phase < SCLK_DIV, otherwise Sclk=1.
  - At phase == SCLK_DIV-1 (the last low cycle, i.e. the SCLK rising edge), shift Sdata into a 16-bit register, LSB in.
  - At phase == 2*SCLK_DIV-1, wrap the phase and increment the bit counter. After bit 15 completes, go to LISTO.
- LISTO (exactly one cycle):
  - CS_n=1, Sclk=1.
  - Register `Uk`, assert `Bandera_ADC`=1, and set `Error_Trama` = OR of shift[15:12].
  - Return to REPOSO.
- Conversion rule:
  - D = shift[11:0], unsigned.
  - s = D − 2048, 13-bit signed, range −2048..2047.
  - Uk = sign-extend(s) << (F−11), so full scale maps to ±1.0 in QN.F.
  - The shift is exact; no rounding or saturation is needed.
- Ticks that arrive in CONV or LISTO are ignored. The SAMPLE_DIV constraint makes this unreachable in legal configurations.
- `Uk` and `Error_Trama` hold their values until the next LISTO.

## Timing
- Reset values: CS_n=1, Sclk=1, Uk=0, Bandera_ADC=0, Error_Trama=0. FSM=REPOSO, and all counters and the shift register = 0.
- Reset asserted mid-conversion aborts the frame immediately: CS_n=1 and Sclk=1 on the next cycle, with no strobe.
- First tick occurs SAMPLE_DIV cycles after the first non-reset edge (timer counts 0..SAMPLE_DIV-1).
- Tick in cycle t:
  - CS_n falls at t+1.
  - CONV spans cycles t+1 .. t+32*SCLK_DIV.
  - Bandera_ADC is high in cycle t+1+32*SCLK_DIV (t+129 at default).
- Strobe period: exactly SAMPLE_DIV cycles, with no jitter.
- Sclk at default: 4 cycles low, 4 cycles high, 16 pulses per frame.
- CS_n high time per period: SAMPLE_DIV − 32*SCLK_DIV cycles.
- `Uk` changes only in the strobe cycle. The filter may sample `Uk` in that cycle or any cycle before the next strobe.

## Test plan
- Reset, then the ADC model returns code 0x800 → first Bandera_ADC pulse in cycle SAMPLE_DIV+32*SCLK_DIV after reset release, with Uk=0 and Error_Trama=0.
- Codes 0xFFF, 0x000, 0x801 → Uk = 0x0007FF0, 0x1FF8000, 0x0000010 respectively (N=25, F=15).
- Frame with a leading bit = 1 (0x1800) → Error_Trama=1 with the strobe and Uk=0. The next clean frame clears Error_Trama.
- Timing check over 3 periods:
  - exactly 16 Sclk rising edges per CS_n-low window;
  - CS_n low for 32*SCLK_DIV cycles;
  - Bandera_ADC is one cycle wide, spaced SAMPLE_DIV apart.
- Reset asserted at bit 7 of a frame → CS_n=1 and Sclk=1 the next cycle, no strobe, Uk=0. The next conversion starts SAMPLE_DIV cycles after release.
- Sweep SCLK_DIV=1 and SCLK_DIV=8 with SAMPLE_DIV=300 → correct data captured, and strobe latency = 1+32*SCLK_DIV after the tick.

Source files
------------

// File: rtl/adc_spi_muestreo.sv
// adc_spi_muestreo: paces ADC7476-style serial conversions and
// presents each sample to the low-pass filter as signed QN.F.
module adc_spi_muestreo #(
    parameter int N          = 25,
    parameter int F          = 15,
    parameter int SCLK_DIV   = 4,
    parameter int SAMPLE_DIV = 20000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Sdata,
    output logic         Sclk,
    output logic         CS_n,
    output logic [N-1:0] Uk,
    output logic         Bandera_ADC,
    output logic         Error_Trama
);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int PW = $clog2(2 * SCLK_DIV);

    localparam logic [TW-1:0] T_LAST  = TW'(SAMPLE_DIV - 1);
    localparam logic [PW-1:0] PH_RISE = PW'(SCLK_DIV - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(SCLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * SCLK_DIV - 1);

    localparam logic [1:0] REPOSO = 2'd0;
    localparam logic [1:0] CONV   = 2'd1;
    localparam logic [1:0] LISTO  = 2'd2;

    logic [TW-1:0]       timer;
    logic                tick;
    logic [1:0]          estado;
    logic [PW-1:0]       fase;
    logic [3:0]          bit_cnt;
    logic [15:0]         trama;
    logic                fin_bit;
    logic                fin_trama;
    logic signed [11:0]  muestra;
    logic signed [N-1:0] uk_next;

    assign tick      = (timer == T_LAST);
    assign fin_bit   = (estado == CONV) && (fase == PH_LAST);
    assign fin_trama = fin_bit && (bit_cnt == 4'd15);

    assign CS_n = (estado != CONV);
    assign Sclk = (estado != CONV) || (fase >= PH_HIGH);

    // Offset-binary to two's complement is a flip of the MSB;
    // the shift aligns full scale with +/-1.0.
    always_comb begin
        muestra = {~trama[11], trama[10:0]};
        uk_next = N'(muestra) <<< (F - 11);
    end

    // Free-running sample timer, independent of the FSM state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Frame sequencer: SCLK phase, bit count and data shift.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado  <= REPOSO;
            fase    <= '0;
            bit_cnt <= '0;
            trama   <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (tick) begin
                        estado  <= CONV;
                        fase    <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONV: begin
                    if (fase == PH_RISE) begin
                        trama <= {trama[14:0], Sdata};
                    end
                    if (fin_bit) begin
                        fase    <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            estado <= LISTO;
                        end
                    end else begin
                        fase <= fase + PW'(1);
                    end
                end
                LISTO: begin
                    estado <= REPOSO;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

    // Result registers load as the FSM enters LISTO, so the
    // strobe cycle already carries the new sample.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Uk          <= '0;
            Bandera_ADC <= 1'b0;
            Error_Trama <= 1'b0;
        end else begin
            Bandera_ADC <= fin_trama;
            if (fin_trama) begin
                Uk          <= uk_next;
                Error_Trama <= |trama[15:12];
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_muestreo.sv
// tb_adc_spi_muestreo: scoreboard bench with a serial ADC model
// per instance; instance 0 is the main DUT, 1 and 2 sweep SCLK_DIV.
`timescale 1ns/1ps
module tb_adc_spi_muestreo;
    localparam int N    = 25;
    localparam int F    = 15;
    localparam int SD0  = 4;
    localparam int SMP0 = 400;
    localparam int SMPS = 300;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   vecs  = 0;
    int   errs  = 0;

    always #5 Clk = ~Clk;

    function automatic logic [N-1:0] exp_uk(input logic [15:0] f);
        int s;
        s = (int'(f[11:0]) - 2048) * (1 << (F - 11));
        return s[N-1:0];
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int SD  = (i == 0) ? SD0 : ((i == 1) ? 1 : 8);
        localparam int SMP = (i == 0) ? SMP0 : SMPS;
        logic         sclk;
        logic         cs_n;
        logic         band;
        logic         err;
        logic         sdata = 1'b0;
        logic [N-1:0] uk;
        logic [15:0]  frame_q[$];
        logic [N:0]   exp_q[$];
        logic [15:0]  cur = 16'h0;
        int           idx = 0;
        logic         prev_cs = 1'b1;
        logic         prev_sclk = 1'b1;

        adc_spi_muestreo #(
            .N(N), .F(F), .SCLK_DIV(SD), .SAMPLE_DIV(SMP)
        ) dut (
            .Clk(Clk), .Reset(Reset), .Sdata(sdata),
            .Sclk(sclk), .CS_n(cs_n), .Uk(uk),
            .Bandera_ADC(band), .Error_Trama(err)
        );

        // ADC model: first bit on CS_n fall, next bit after each SCLK fall.
        always @(posedge Clk) begin
            #1;
            if (prev_cs === 1'b1 && cs_n === 1'b0) begin
                if (frame_q.size() > 0) cur = frame_q.pop_front();
                else cur = 16'h0800;
                exp_q.push_back({|cur[15:12], exp_uk(cur)});
                idx = 0;
                sdata = cur[15];
            end else if (cs_n === 1'b0 && prev_sclk === 1'b1 &&
                         sclk === 1'b0 && idx < 15) begin
                idx++;
                sdata = cur[15-idx];
            end
            prev_cs = cs_n;
            prev_sclk = sclk;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic peek(input int i, output logic b, output logic c,
                        output logic s, output logic [N-1:0] u,
                        output logic e);
        case (i)
            0: begin b = g[0].band; c = g[0].cs_n; s = g[0].sclk; u = g[0].uk; e = g[0].err; end
            1: begin b = g[1].band; c = g[1].cs_n; s = g[1].sclk; u = g[1].uk; e = g[1].err; end
            default: begin b = g[2].band; c = g[2].cs_n; s = g[2].sclk; u = g[2].uk; e = g[2].err; end
        endcase
    endtask

    task automatic push_frame(input int i, input logic [15:0] f);
        case (i)
            0: g[0].frame_q.push_back(f);
            1: g[1].frame_q.push_back(f);
            default: g[2].frame_q.push_back(f);
        endcase
    endtask

    task automatic pop_exp(input int i, output bit ok, output logic [N:0] v);
        ok = 1'b0;
        v = '0;
        case (i)
            0: if (g[0].exp_q.size() > 0) begin v = g[0].exp_q.pop_front(); ok = 1'b1; end
            1: if (g[1].exp_q.size() > 0) begin v = g[1].exp_q.pop_front(); ok = 1'b1; end
            default: if (g[2].exp_q.size() > 0) begin v = g[2].exp_q.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic clear_exp();
        g[0].exp_q.delete();
        g[1].exp_q.delete();
        g[2].exp_q.delete();
    endtask

    task automatic wait_strobe(input int i, input int budget,
                               output bit ok, output int k);
        logic b, c, s, e;
        logic [N-1:0] u;
        ok = 1'b0;
        k = 0;
        while (!ok && k < budget) begin
            step();
            k++;
            peek(i, b, c, s, u, e);
            if (b === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic b, c, s, e;
        logic [N-1:0] u;
        Reset = 1'b1;
        repeat (3) step();
        peek(0, b, c, s, u, e);
        vecs++; if (c !== 1'b1) begin errs++; $display("FAIL reset_cs_n: got %b want 1", c); end
        vecs++; if (s !== 1'b1) begin errs++; $display("FAIL reset_sclk: got %b want 1", s); end
        vecs++; if (u !== '0) begin errs++; $display("FAIL reset_uk: got %h want 0", u); end
        vecs++; if (b !== 1'b0) begin errs++; $display("FAIL reset_strobe: got %b want 0", b); end
        vecs++; if (e !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", e); end
        clear_exp();
        push_frame(0, 16'h0800);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_first_sample();
        logic b, c, s, e;
        logic [N-1:0] u;
        logic [N:0] v;
        bit ok, okq;
        int k;
        wait_strobe(0, 2 * SMP0, ok, k);
        vecs++;
        if (!ok) begin
            errs++; $display("FAIL first_strobe: none within %0d cycles", 2 * SMP0);
        end else begin
            if (k !== SMP0 + 32 * SD0) begin errs++; $display("FAIL first_latency: got %0d want %0d", k, SMP0 + 32 * SD0); end
            peek(0, b, c, s, u, e);
            pop_exp(0, okq, v);
            vecs++; if (!okq || u !== v[N-1:0] || u !== '0) begin errs++; $display("FAIL first_uk: got %h want 0", u); end
            vecs++; if (e !== 1'b0) begin errs++; $display("FAIL first_err: got %b want 0", e); end
        end
    endtask

    task automatic test_codes();
        logic b, c, s, e;
        logic [N-1:0] u;
        logic [N:0] v;
        logic [15:0] codes [3];
        logic [N-1:0] tab [3];
        bit ok, okq;
        int k;
        codes[0] = 16'h0FFF; tab[0] = 25'h0007FF0;
        codes[1] = 16'h0000; tab[1] = 25'h1FF8000;
        codes[2] = 16'h0801; tab[2] = 25'h0000010;
        for (int i = 0; i < 3; i++) push_frame(0, codes[i]);
        for (int i = 0; i < 3; i++) begin
            wait_strobe(0, SMP0 + 10, ok, k);
            vecs++;
            if (!ok) begin
                errs++; $display("FAIL code_strobe[%0d]: timeout", i);
            end else begin
                if (k !== SMP0) begin errs++; $display("FAIL code_period[%0d]: got %0d want %0d", i, k, SMP0); end
                peek(0, b, c, s, u, e);
                pop_exp(0, okq, v);
                vecs++; if (!okq || u !== v[N-1:0]) begin errs++; $display("FAIL code_uk_sb[%0d]: got %h want %h", i, u, v[N-1:0]); end
                vecs++; if (u !== tab[i]) begin errs++; $display("FAIL code_uk[%0d]: got %h want %h", i, u, tab[i]); end
                vecs++; if (e !== 1'b0) begin errs++; $display("FAIL code_err[%0d]: got %b want 0", i, e); end
            end
        end
    endtask

    task automatic test_frame_error();
        logic b, c, s, e;
        logic [N-1:0] u;
        logic [N:0] v;
        logic [1:0] want_e;
        bit ok, okq;
        int k;
        want_e = 2'b01;
        push_frame(0, 16'h1800);
        push_frame(0, 16'h0ABC);
        for (int i = 0; i < 2; i++) begin
            wait_strobe(0, SMP0 + 10, ok, k);
            vecs++;
            if (!ok) begin
                errs++; $display("FAIL err_strobe[%0d]: timeout", i);
            end else begin
                peek(0, b, c, s, u, e);
                pop_exp(0, okq, v);
                if (!okq || u !== v[N-1:0]) begin errs++; $display("FAIL err_uk[%0d]: got %h want %h", i, u, v[N-1:0]); end
                vecs++; if (e !== want_e[i] || e !== v[N]) begin errs++; $display("FAIL err_flag[%0d]: got %b want %b", i, e, want_e[i]); end
            end
        end
    endtask

    task automatic test_timing();
        logic b, c, s, e;
        logic [N-1:0] u;
        logic [N:0] v;
        logic pb, pc, ps;
        bit okq;
        int low, rises, last, nwin, nstb;
        pb = 1'b0; pc = 1'b1; ps = 1'b1;
        low = 0; rises = 0; last = -1; nwin = 0; nstb = 0;
        for (int i = 0; i < 3; i++) push_frame(0, 16'h0C34);
        for (int k = 1; k <= 3 * SMP0; k++) begin
            step();
            peek(0, b, c, s, u, e);
            if (c === 1'b0) begin
                low++;
                if (ps === 1'b0 && s === 1'b1) rises++;
            end
            if (pc === 1'b0 && c === 1'b1) begin
                nwin++;
                vecs++;
                if (rises !== 16 || low !== 32 * SD0) begin
                    errs++; $display("FAIL window[%0d]: rises %0d low %0d want 16 and %0d", nwin, rises, low, 32 * SD0);
                end
                low = 0; rises = 0;
            end
            if (b === 1'b1) begin
                nstb++;
                vecs++; if (pb === 1'b1) begin errs++; $display("FAIL strobe_width: high two cycles at %0d", k); end
                if (last >= 0) begin
                    vecs++; if (k - last !== SMP0) begin errs++; $display("FAIL strobe_gap: got %0d want %0d", k - last, SMP0); end
                end
                last = k;
                pop_exp(0, okq, v);
                vecs++; if (!okq || u !== v[N-1:0]) begin errs++; $display("FAIL timing_uk: got %h want %h", u, v[N-1:0]); end
            end
            pb = b; pc = c; ps = s;
        end
        vecs++;
        if (nwin !== 3 || nstb !== 3) begin errs++; $display("FAIL timing_count: windows %0d strobes %0d want 3 and 3", nwin, nstb); end
    endtask

    task automatic test_reset_abort();
        logic b, c, s, e;
        logic [N-1:0] u;
        logic [N:0] v;
        bit ok, okq, early;
        int k;
        push_frame(0, 16'h0FFF);
        c = 1'b1; k = 0;
        while (c !== 1'b0 && k < 2 * SMP0) begin step(); k++; peek(0, b, c, s, u, e); end
        repeat (58) step();
        peek(0, b, c, s, u, e);
        vecs++; if (c !== 1'b0) begin errs++; $display("FAIL abort_in_conv: cs_n %b want 0", c); end
        @(negedge Clk);
        Reset = 1'b1;
        step();
        peek(0, b, c, s, u, e);
        vecs++; if (c !== 1'b1 || s !== 1'b1) begin errs++; $display("FAIL abort_lines: cs_n %b sclk %b want 1 1", c, s); end
        vecs++; if (b !== 1'b0 || u !== '0) begin errs++; $display("FAIL abort_out: strobe %b uk %h want 0 0", b, u); end
        @(negedge Clk);
        Reset = 1'b0;
        clear_exp();
        push_frame(0, 16'h0123);
        k = 0; early = 1'b0; c = 1'b1;
        while (c !== 1'b0 && k < 2 * SMP0) begin
            step(); k++;
            peek(0, b, c, s, u, e);
            if (b === 1'b1) early = 1'b1;
        end
        vecs++; if (k !== SMP0 || early) begin errs++; $display("FAIL abort_restart: cs fall %0d want %0d, strobe %b", k, SMP0, early); end
        wait_strobe(0, 2 * SMP0, ok, k);
        vecs++;
        if (!ok || k !== 32 * SD0) begin
            errs++; $display("FAIL abort_latency: got %0d want %0d", k, 32 * SD0);
        end else begin
            peek(0, b, c, s, u, e);
            pop_exp(0, okq, v);
            vecs++; if (!okq || u !== v[N-1:0] || e !== v[N]) begin errs++; $display("FAIL abort_data: got %h want %h", u, v[N-1:0]); end
        end
    endtask

    task automatic test_sclk_sweep();
        logic b, c, s, e;
        logic [N-1:0] u;
        logic [N:0] v;
        bit okq;
        int n [3];
        int last [3];
        int sd, want;
        @(negedge Clk);
        Reset = 1'b1;
        step();
        step();
        @(negedge Clk);
        Reset = 1'b0;
        clear_exp();
        push_frame(1, 16'h0A5C); push_frame(1, 16'h0123);
        push_frame(2, 16'h03E7); push_frame(2, 16'h0FFE);
        n[1] = 0; n[2] = 0; last[1] = 0; last[2] = 0;
        for (int k = 1; k <= 2 * SMPS + 600; k++) begin
            step();
            for (int j = 1; j <= 2; j++) begin
                peek(j, b, c, s, u, e);
                if (b === 1'b1) begin
                    sd = (j == 1) ? 1 : 8;
                    n[j]++;
                    want = (n[j] == 1) ? SMPS + 32 * sd : last[j] + SMPS;
                    last[j] = k;
                    vecs++; if (k !== want) begin errs++; $display("FAIL sweep%0d_time: strobe at %0d want %0d", sd, k, want); end
                    pop_exp(j, okq, v);
                    vecs++; if (!okq || u !== v[N-1:0] || e !== v[N]) begin errs++; $display("FAIL sweep%0d_data: got %h want %h", sd, u, v[N-1:0]); end
                end
            end
            if (n[1] >= 2 && n[2] >= 2) break;
        end
        vecs++;
        if (n[1] !== 2 || n[2] !== 2) begin errs++; $display("FAIL sweep_count: got %0d and %0d strobes want 2 and 2", n[1], n[2]); end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_codes();
        test_frame_error();
        test_timing();
        test_reset_abort();
        test_sclk_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
